// File: rtl/sgpio_tx_multi_if.sv
// SGPIO transmitter bundle: host-side status inputs, serial link outputs and frame status.
// The master modport is the transmitter; the slave modport is whatever drives and observes it.
interface sgpio_tx_multi_if #(
    parameter int NUM_DRV = 36
);
    logic               EN;
    logic [NUM_DRV-1:0] DRV_ACT;
    logic [NUM_DRV-1:0] DRV_LOC;
    logic [NUM_DRV-1:0] DRV_FLT;
    logic [3:0]         VENDOR;
    logic               SGPIO_CK;
    logic               SGPIO_LD;
    logic               SGPIO_DATA;
    logic               BUSY;
    logic               FRAME_DONE;
    logic [7:0]         FRAME_CNT;

    modport master (
        input  EN, DRV_ACT, DRV_LOC, DRV_FLT, VENDOR,
        output SGPIO_CK, SGPIO_LD, SGPIO_DATA, BUSY, FRAME_DONE, FRAME_CNT
    );

    modport slave (
        output EN, DRV_ACT, DRV_LOC, DRV_FLT, VENDOR,
        input  SGPIO_CK, SGPIO_LD, SGPIO_DATA, BUSY, FRAME_DONE, FRAME_CNT
    );
endinterface

// File: rtl/sgpio_tx_multi.sv
// SGPIO transmitter: serialises per-drive ACT/LOC/FLT plus vendor bits on SGPIO_LD.
//   state   | meaning
//   S_IDLE  | link quiet, CK/LD/DATA low, waiting for EN
//   S_SHIFT | frame in progress, one slot per 2*CLK_DIV cycles
module sgpio_tx_multi #(
    parameter int NUM_DRV      = 36,
    parameter int BITS_PER_DRV = 3,
    parameter int CLK_DIV      = 50
) (
    input  logic             SYSCLK,
    input  logic             RESET,
    sgpio_tx_multi_if.master bus
);

    localparam int N      = NUM_DRV * BITS_PER_DRV;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = $clog2(N);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N - 1);

    if (N < 5 || BITS_PER_DRV < 1 || BITS_PER_DRV > 3 || CLK_DIV < 1) begin : g_cfg_err
        $error("sgpio_tx_multi: unsupported parameter set");
    end

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                ck_q, ck_d;
    logic                ld_q, ld_d;
    logic                data_q, data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [N-1:0]        data_sr_q, data_sr_d;
    logic [N-1:0]        ld_sr_q, ld_sr_d;
    logic [NUM_DRV-1:0]  act_sticky_q, act_sticky_d;

    logic [NUM_DRV-1:0]  act_eff;
    logic [N-1:0]        frame_vec;
    logic [N-1:0]        ld_vec;
    logic                start;

    assign act_eff = act_sticky_q | bus.DRV_ACT;
    assign ld_vec  = N'({bus.VENDOR, 1'b1});

    for (genvar k = 0; k < N; k++) begin : g_slot
        localparam int DRV = k / BITS_PER_DRV;
        localparam int BIT = k % BITS_PER_DRV;
        if (BIT == 0) begin : g_act
            assign frame_vec[k] = act_eff[DRV];
        end else if (BIT == 1) begin : g_loc
            assign frame_vec[k] = bus.DRV_LOC[DRV];
        end else begin : g_flt
            assign frame_vec[k] = bus.DRV_FLT[DRV];
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        slot_d       = slot_q;
        ck_d         = ck_q;
        ld_d         = ld_q;
        data_d       = data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        data_sr_d    = data_sr_q;
        ld_sr_d      = ld_sr_q;
        act_sticky_d = act_eff;
        start        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.EN) start = 1'b1;
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    div_d = DIV_LAST;
                    if (!ck_q) begin
                        ck_d = 1'b1;
                    end else begin
                        ck_d = 1'b0;
                        if (slot_q == SLOT_LAST) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            if (bus.EN) begin
                                start = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                div_d   = '0;
                                slot_d  = '0;
                                ld_d    = 1'b0;
                                data_d  = 1'b0;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            slot_d    = slot_q + SLOT_W'(1);
                            data_d    = data_sr_q[0];
                            ld_d      = ld_sr_q[0];
                            data_sr_d = data_sr_q >> 1;
                            ld_sr_d   = ld_sr_q >> 1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Snapshot: whole frame latched at once, sticky ACT restarts from this cycle's input.
        if (start) begin
            state_d      = S_SHIFT;
            busy_d       = 1'b1;
            ck_d         = 1'b0;
            div_d        = DIV_LAST;
            slot_d       = '0;
            data_d       = frame_vec[0];
            ld_d         = ld_vec[0];
            data_sr_d    = frame_vec >> 1;
            ld_sr_d      = ld_vec >> 1;
            act_sticky_d = bus.DRV_ACT;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            slot_q       <= '0;
            ck_q         <= 1'b0;
            ld_q         <= 1'b0;
            data_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            data_sr_q    <= '0;
            ld_sr_q      <= '0;
            act_sticky_q <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            slot_q       <= slot_d;
            ck_q         <= ck_d;
            ld_q         <= ld_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            data_sr_q    <= data_sr_d;
            ld_sr_q      <= ld_sr_d;
            act_sticky_q <= act_sticky_d;
        end
    end

    assign bus.SGPIO_CK   = ck_q;
    assign bus.SGPIO_LD   = ld_q;
    assign bus.SGPIO_DATA = data_q;
    assign bus.BUSY       = busy_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_sgpio_tx_multi.sv
// Bench for sgpio_tx_multi (4 drives, 3 bits, CLK_DIV=2): expected slots go into a queue,
// a negedge monitor pops one entry per SGPIO_CK rise and compares DATA/LD.
module tb_sgpio_tx_multi;

    typedef struct packed {
        logic data;
        logic ld;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    int ld_rise_cnt = 0;
    exp_t sb_q[$];

    sgpio_tx_multi_if #(.NUM_DRV(4)) bus ();

    sgpio_tx_multi #(
        .NUM_DRV(4),
        .BITS_PER_DRV(3),
        .CLK_DIV(2)
    ) dut (
        .SYSCLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Vectors are written slot 0 leftmost.
    task automatic push_slots(input logic [11:0] data, input logic [11:0] ld, input int nslots);
        exp_t e;
        for (int i = 0; i < nslots; i++) begin
            e.data = data[11-i];
            e.ld   = ld[11-i];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int n);
        n = 0;
        while (bus.BUSY === 1'b1 && n < max_cyc) begin
            tick(1);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.EN = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Monitor: runs on the falling SYSCLK edge, away from DUT updates.
    logic prev_ck = 1'b0;
    logic prev_ld = 1'b0;
    logic prev_fd = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_ck === 1'b0 && bus.SGPIO_CK === 1'b1) begin
            rise_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ck_rise_unexpected: rise %0d with empty scoreboard", rise_cnt);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("slot_data_ld rise %0d", rise_cnt),
                      {30'd0, bus.SGPIO_DATA, bus.SGPIO_LD}, {30'd0, e.data, e.ld});
            end
        end
        if (prev_ld === 1'b0 && bus.SGPIO_LD === 1'b1) ld_rise_cnt++;
        if (bus.FRAME_DONE === 1'b1) begin
            done_cnt++;
            check("frame_done_single_cycle", {31'd0, prev_fd}, 32'd0);
        end
        prev_ck = bus.SGPIO_CK;
        prev_ld = bus.SGPIO_LD;
        prev_fd = bus.FRAME_DONE;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int d0;
        int l0;
        logic bad;

        rst         = 1'b1;
        bus.EN      = 1'b0;
        bus.DRV_ACT = '0;
        bus.DRV_LOC = '0;
        bus.DRV_FLT = '0;
        bus.VENDOR  = '0;

        // Reset / idle
        tick(5);
        check("rst_ck", {31'd0, bus.SGPIO_CK}, 32'd0);
        check("rst_ld", {31'd0, bus.SGPIO_LD}, 32'd0);
        check("rst_data", {31'd0, bus.SGPIO_DATA}, 32'd0);
        check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check("rst_frame_done", {31'd0, bus.FRAME_DONE}, 32'd0);
        check("rst_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd0);
        rst = 1'b0;
        r0 = rise_cnt;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            bad = bad | bus.SGPIO_CK | bus.SGPIO_LD | bus.SGPIO_DATA | bus.BUSY |
                  bus.FRAME_DONE | (bus.FRAME_CNT != 8'd0);
        end
        check("idle_outputs_static", {31'd0, bad}, 32'd0);
        check("idle_ck_rises", rise_cnt - r0, 32'd0);

        // Single frame with a one-cycle EN pulse
        bus.DRV_ACT = 4'b0101;
        bus.DRV_LOC = 4'b0010;
        bus.DRV_FLT = 4'b1000;
        bus.VENDOR  = 4'b1010;
        push_slots(12'b100_010_100_001, 12'b101010000000, 12);
        r0 = rise_cnt;
        d0 = done_cnt;
        bus.EN = 1'b1;
        tick(1);
        bus.EN = 1'b0;
        check("start_busy", {31'd0, bus.BUSY}, 32'd1);
        check("start_ck_low", {31'd0, bus.SGPIO_CK}, 32'd0);
        check("start_ld_slot0", {31'd0, bus.SGPIO_LD}, 32'd1);
        check("start_data_slot0", {31'd0, bus.SGPIO_DATA}, 32'd1);
        tick(1);
        check("ck_low_phase", {31'd0, bus.SGPIO_CK}, 32'd0);
        tick(1);
        check("ck_first_rise", {31'd0, bus.SGPIO_CK}, 32'd1);
        wait_idle(200, n);
        check("single_frame_length", n + 2, 32'd48);
        check("single_frame_done_at_end", {31'd0, bus.FRAME_DONE}, 32'd1);
        check("single_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd1);
        check("single_idle_ld", {31'd0, bus.SGPIO_LD}, 32'd0);
        check("single_idle_data", {31'd0, bus.SGPIO_DATA}, 32'd0);
        tick(20);
        check("single_ck_rises", rise_cnt - r0, 32'd12);
        check("single_done_pulses", done_cnt - d0, 32'd1);
        check("single_sb_drained", sb_q.size(), 32'd0);

        // Sticky ACT: pulse on drive 2 during slot 6 of frame 0
        do_reset();
        bus.DRV_ACT = '0;
        bus.DRV_LOC = '0;
        bus.DRV_FLT = '0;
        bus.VENDOR  = '0;
        tick(2);
        push_slots(12'b000_000_000_000, 12'b100000000000, 12);
        push_slots(12'b000_000_100_000, 12'b100000000000, 12);
        push_slots(12'b000_000_000_000, 12'b100000000000, 12);
        bus.EN = 1'b1;
        tick(1);
        tick(25);
        bus.DRV_ACT = 4'b0100;
        tick(1);
        bus.DRV_ACT = 4'b0000;
        tick(74);
        bus.EN = 1'b0;
        wait_idle(200, n);
        check("sticky_three_frames_length", n + 100, 32'd144);
        check("sticky_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd3);
        tick(2);
        check("sticky_sb_drained", sb_q.size(), 32'd0);

        // Mid-frame FLT change, then EN drop in slot 5 of the second frame
        do_reset();
        tick(2);
        push_slots(12'b000_000_000_000, 12'b100000000000, 12);
        push_slots(12'b001_001_001_001, 12'b100000000000, 12);
        r0 = rise_cnt;
        l0 = ld_rise_cnt;
        bus.EN = 1'b1;
        tick(1);
        tick(13);
        bus.DRV_FLT = 4'hF;
        tick(56);
        bus.EN = 1'b0;
        wait_idle(200, n);
        check("en_drop_frame_end", n + 69, 32'd96);
        check("en_drop_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd2);
        tick(30);
        check("en_drop_ck_rises", rise_cnt - r0, 32'd24);
        check("en_drop_ld_pulses", ld_rise_cnt - l0, 32'd2);
        check("en_drop_sb_drained", sb_q.size(), 32'd0);

        // RESET in slot 7 of the second frame
        do_reset();
        bus.DRV_ACT = 4'b0011;
        bus.DRV_FLT = 4'h0;
        bus.VENDOR  = 4'b0110;
        tick(2);
        push_slots(12'b100_100_000_000, 12'b101100000000, 12);
        push_slots(12'b100_100_000_000, 12'b101100000000, 7);
        bus.EN = 1'b1;
        tick(1);
        tick(77);
        check("pre_reset_busy", {31'd0, bus.BUSY}, 32'd1);
        check("pre_reset_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd1);
        rst = 1'b1;
        bus.EN = 1'b0;
        tick(1);
        check("midrst_ck", {31'd0, bus.SGPIO_CK}, 32'd0);
        check("midrst_ld", {31'd0, bus.SGPIO_LD}, 32'd0);
        check("midrst_data", {31'd0, bus.SGPIO_DATA}, 32'd0);
        check("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
        check("midrst_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd0);
        rst = 1'b0;
        tick(10);
        check("midrst_sb_drained", sb_q.size(), 32'd0);

        // 256 back-to-back frames: FRAME_CNT wraps to 0
        do_reset();
        bus.DRV_ACT = '0;
        bus.DRV_LOC = '0;
        bus.DRV_FLT = '0;
        bus.VENDOR  = '0;
        tick(2);
        for (int f = 0; f < 256; f++) push_slots(12'b0, 12'b100000000000, 12);
        d0 = done_cnt;
        bus.EN = 1'b1;
        tick(1);
        tick(12250);
        check("wrap_cnt_before_last", {24'd0, bus.FRAME_CNT}, 32'd255);
        bus.EN = 1'b0;
        wait_idle(200, n);
        check("wrap_last_frame_end", n + 12250, 32'd12288);
        check("wrap_frame_cnt", {24'd0, bus.FRAME_CNT}, 32'd0);
        tick(2);
        check("wrap_done_pulses", done_cnt - d0, 32'd256);
        check("wrap_sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
